// File: rtl/spi_flash_responder.sv
// SPI-flash slave model (mode 0) serving READ (0x03) and JEDEC-ID (0x9F)
// from an internal byte array. The SPI pins are oversampled on the system clock.
// Optional: define SPI_RESP_FAST_READ_EN to also accept FAST READ (0x0B).
`timescale 1ns / 1ps

module spi_flash_responder #(
   parameter int unsigned MEM_BYTES   = 65536,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         i_sclk,
   input  logic                         i_cs_n,
   input  logic                         i_mosi,
   output logic                         o_miso,
   input  logic                         i_ld_we,
   input  logic [$clog2(MEM_BYTES)-1:0] i_ld_addr,
   input  logic [7:0]                   i_ld_data,
   output logic                         o_busy,
   output logic                         o_cmd_valid,
   output logic [7:0]                   o_cmd,
   output logic                         o_err
);

   localparam int unsigned AW = $clog2(MEM_BYTES);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StDummy,
      StData,
      StId,
      StIgnore
   } state_e;

   // Backdoor-loadable storage; not reset
   logic [7:0] mem [MEM_BYTES];

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;

   state_e      state_q;
   logic [4:0]  cnt_q;
   logic [23:0] shift_q;   // bits [23:16] hold the byte being shifted out
   logic [7:0]  nxt_q;     // prefetched next data byte
   logic [23:0] addr_q;
   logic        load_q;    // first data byte is fetched the cycle after the address completes
`ifdef SPI_RESP_FAST_READ_EN
   logic        fast_q;
`endif

   logic       sclk_s;
   logic       cs_s;
   logic       mosi_s;
   logic       sclk_rise;
   logic       sclk_fall;
   logic [7:0] cmd_byte;
   logic [7:0] rd_byte;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cmd_byte  = {shift_q[6:0], mosi_s};
   // Upper address bits are ignored, so the array aliases across the 24-bit space
   assign rd_byte   = mem[addr_q[AW-1:0]];

   // Synchronize the SPI pins and remember the previous sclk level for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
         sclk_prev_q <= sclk_s;
      end
   end

   // Backdoor preload port; a same-cycle prefetch of this address sees the old byte
   always_ff @(posedge clk) begin
      if (i_ld_we) begin
         mem[i_ld_addr] <= i_ld_data;
      end
   end

   // Protocol FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shift_q     <= '0;
         nxt_q       <= '0;
         addr_q      <= '0;
         load_q      <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
         fast_q      <= 1'b0;
`endif
         o_miso      <= 1'b0;
         o_busy      <= 1'b0;
         o_cmd_valid <= 1'b0;
         o_cmd       <= 8'h00;
         o_err       <= 1'b0;
      end else begin
         o_cmd_valid <= 1'b0;
         o_err       <= 1'b0;
         o_busy      <= ~cs_s;
         load_q      <= 1'b0;
         if (cs_s) begin
            // Deselect aborts any transfer, including a partial byte
            state_q <= StIdle;
            cnt_q   <= '0;
            o_miso  <= 1'b0;
         end else begin
            if (load_q) begin
               shift_q <= {rd_byte, 16'h0000};
               addr_q  <= addr_q + 24'd1;
            end
            unique case (state_q)
               StIdle: begin
                  state_q <= StCmd;
                  cnt_q   <= '0;
               end
               StCmd: begin
                  if (sclk_rise) begin
                     shift_q <= {shift_q[22:0], mosi_s};
                     cnt_q   <= cnt_q + 5'd1;
                     if (cnt_q == 5'd7) begin
                        cnt_q       <= '0;
                        o_cmd       <= cmd_byte;
                        o_cmd_valid <= 1'b1;
                        case (cmd_byte)
                           8'h03: begin
                              state_q <= StAddr;
`ifdef SPI_RESP_FAST_READ_EN
                              fast_q  <= 1'b0;
`endif
                           end
`ifdef SPI_RESP_FAST_READ_EN
                           8'h0B: begin
                              state_q <= StAddr;
                              fast_q  <= 1'b1;
                           end
`endif
                           8'h9F: begin
                              state_q <= StId;
                              shift_q <= JEDEC_ID;
                           end
                           default: begin
                              state_q <= StIgnore;
                              o_err   <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               StAddr: begin
                  if (sclk_rise) begin
                     addr_q <= {addr_q[22:0], mosi_s};
                     cnt_q  <= cnt_q + 5'd1;
                     if (cnt_q == 5'd23) begin
                        cnt_q   <= '0;
                        load_q  <= 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
                        state_q <= fast_q ? StDummy : StData;
`else
                        state_q <= StData;
`endif
                     end
                  end
               end
               StDummy: begin
                  if (sclk_rise) begin
                     cnt_q <= cnt_q + 5'd1;
                     if (cnt_q == 5'd7) begin
                        cnt_q   <= '0;
                        state_q <= StData;
                     end
                  end
               end
               StData: begin
                  if (sclk_fall) begin
                     o_miso <= shift_q[23];
                     cnt_q  <= cnt_q + 5'd1;
                     if (cnt_q[2:0] == 3'd0) begin
                        // Fetch the following byte early so the byte boundary has no gap
                        nxt_q  <= rd_byte;
                        addr_q <= addr_q + 24'd1;
                     end
                     if (cnt_q[2:0] == 3'd7) begin
                        cnt_q   <= '0;
                        shift_q <= {nxt_q, 16'h0000};
                     end else begin
                        shift_q <= {shift_q[22:0], 1'b0};
                     end
                  end
               end
               StId: begin
                  // Zeros shift in behind the ID, so the line reads 0 afterwards
                  if (sclk_fall) begin
                     o_miso  <= shift_q[23];
                     shift_q <= {shift_q[22:0], 1'b0};
                  end
               end
               StIgnore: begin
                  o_miso <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder with queue-based scoreboard.
// Honours SPI_RESP_FAST_READ_EN the same way as the design.
`timescale 1ns / 1ps

module tb_spi_flash_responder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       i_sclk = 1'b0;
   logic       i_cs_n = 1'b1;
   logic       i_mosi = 1'b0;
   logic       o_miso;
   logic       i_ld_we = 1'b0;
   logic [7:0] i_ld_addr = '0;
   logic [7:0] i_ld_data = '0;
   logic       o_busy;
   logic       o_cmd_valid;
   logic [7:0] o_cmd;
   logic       o_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] dq[$];   // expected miso bytes
   logic [8:0] cq[$];   // expected {err, cmd} per command pulse
   logic       rd_en = 1'b0;
   logic [7:0] mon_byte = '0;
   int         mon_cnt = 0;

   spi_flash_responder #(
      .MEM_BYTES  (256),
      .JEDEC_ID   (24'hEF4016),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_sclk     (i_sclk),
      .i_cs_n     (i_cs_n),
      .i_mosi     (i_mosi),
      .o_miso     (o_miso),
      .i_ld_we    (i_ld_we),
      .i_ld_addr  (i_ld_addr),
      .i_ld_data  (i_ld_data),
      .o_busy     (o_busy),
      .o_cmd_valid(o_cmd_valid),
      .o_cmd      (o_cmd),
      .o_err      (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Data monitor: assemble miso bytes at the master's sampling edge
   always @(posedge i_sclk) begin
      if (rd_en) begin
         mon_byte = {mon_byte[6:0], o_miso};
         mon_cnt++;
         if (mon_cnt == 8) begin
            mon_cnt = 0;
            if (dq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL miso_byte: got %0h expected none", mon_byte);
            end else begin
               check("miso_byte", {24'h0, mon_byte}, {24'h0, dq.pop_front()});
            end
         end
      end
   end

   // Command monitor: every o_cmd_valid pulse consumes one expectation
   always @(negedge clk) begin
      if (o_cmd_valid) begin
         if (cq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_pulse: got cmd %0h expected no pulse", o_cmd);
         end else begin
            logic [8:0] e;
            e = cq.pop_front();
            check("cmd", {24'h0, o_cmd}, {24'h0, e[7:0]});
            check("err", {31'h0, o_err}, {31'h0, e[8]});
         end
      end else if (o_err) begin
         checks++;
         errors++;
         $display("FAIL err_alone: got o_err 1 expected 0 without o_cmd_valid");
      end
   end

   task automatic sclk_cycle(input logic b);
      i_mosi = b;
      #80 i_sclk = 1'b1;
      #80 i_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sclk_cycle(b[i]);
   endtask

   task automatic read_bytes(input int n);
      rd_en = 1'b1;
      repeat (n * 8) sclk_cycle(1'b0);
      rd_en = 1'b0;
   endtask

   task automatic cs_low();
      i_cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #80 i_cs_n = 1'b1;
      #100;
   endtask

   task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] a);
      cs_low();
      send_byte(cmd);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic ld(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      i_ld_we   = 1'b1;
      i_ld_addr = a;
      i_ld_data = d;
      @(negedge clk);
      i_ld_we   = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before 900us");
      $fatal(1);
   end

   initial begin
      // Reset state
      #23;
      check("rst_miso", {31'h0, o_miso}, 32'h0);
      check("rst_busy", {31'h0, o_busy}, 32'h0);
      check("rst_cmd_valid", {31'h0, o_cmd_valid}, 32'h0);
      check("rst_cmd", {24'h0, o_cmd}, 32'h0);
      check("rst_err", {31'h0, o_err}, 32'h0);
      #20 reset_n = 1'b1;

      ld(8'h10, 8'hDE);
      ld(8'h11, 8'hAD);
      ld(8'h12, 8'hBE);
      ld(8'h13, 8'hEF);
      ld(8'hFF, 8'h11);
      ld(8'h00, 8'h22);

      // READ streaming four bytes
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'hDE); dq.push_back(8'hAD); dq.push_back(8'hBE); dq.push_back(8'hEF);
      cs_low();
      check("busy_active", {31'h0, o_busy}, 32'h1);
      send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      read_bytes(4);
      cs_high();
      check("busy_idle", {31'h0, o_busy}, 32'h0);
      check("cmd_hold", {24'h0, o_cmd}, 32'h03);

      // Address wrap at the top of the array
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'h11); dq.push_back(8'h22);
      start_cmd(8'h03, 24'h0000FF);
      read_bytes(2);
      cs_high();

      // JEDEC ID then zeros
      cq.push_back({1'b0, 8'h9F});
      dq.push_back(8'hEF); dq.push_back(8'h40); dq.push_back(8'h16); dq.push_back(8'h00);
      cs_low();
      send_byte(8'h9F);
      read_bytes(4);
      cs_high();

      // Unsupported command is ignored until deselect
      cq.push_back({1'b1, 8'h5A});
      dq.push_back(8'h00); dq.push_back(8'h00);
      cs_low();
      send_byte(8'h5A);
      read_bytes(2);
      check("busy_ignore", {31'h0, o_busy}, 32'h1);
      cs_high();
      check("busy_after_ignore", {31'h0, o_busy}, 32'h0);

      // Abort mid-byte, then a clean restart
      cq.push_back({1'b0, 8'h03});
      start_cmd(8'h03, 24'h000010);
      repeat (3) sclk_cycle(1'b0);
      cs_high();
      check("miso_after_abort", {31'h0, o_miso}, 32'h0);
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'hAD);
      start_cmd(8'h03, 24'h000011);
      read_bytes(1);
      cs_high();

      // Upper address bits alias onto the array
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'hDE);
      start_cmd(8'h03, 24'h000110);
      read_bytes(1);
      cs_high();

      // Asynchronous reset in the middle of a data stream
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'hDE);
      start_cmd(8'h03, 24'h000010);
      read_bytes(1);
      #60;
      check("miso_next_bit7", {31'h0, o_miso}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_miso", {31'h0, o_miso}, 32'h0);
      check("rst_mid_busy", {31'h0, o_busy}, 32'h0);
      check("rst_mid_cmd", {24'h0, o_cmd}, 32'h0);
      i_cs_n = 1'b1;
      #50 reset_n = 1'b1;
      #100;
      cq.push_back({1'b0, 8'h03});
      dq.push_back(8'hBE); dq.push_back(8'hEF);
      start_cmd(8'h03, 24'h000012);
      read_bytes(2);
      cs_high();

      // FAST READ handling depends on the build option
`ifdef SPI_RESP_FAST_READ_EN
      cq.push_back({1'b0, 8'h0B});
      dq.push_back(8'h00); dq.push_back(8'hDE);
      start_cmd(8'h0B, 24'h000010);
      read_bytes(2);
      cs_high();
`else
      cq.push_back({1'b1, 8'h0B});
      dq.push_back(8'h00); dq.push_back(8'h00);
      cs_low();
      send_byte(8'h0B);
      read_bytes(2);
      cs_high();
`endif

      #200;
      check("data_queue_drained", dq.size(), 32'd0);
      check("cmd_queue_drained", cq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
